// File: rtl/pe_mac_simd.sv
// Multi-lane weight-stationary MAC processing element: 3-stage LANES-wide dot product
// with systolic pass-down or local (output-stationary) accumulation, saturating or wrapping.
module pe_mac_simd #(
    parameter int unsigned IF_W      = 8,
    parameter int unsigned FLT_W     = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned PSUM_W    = 24,
    parameter int unsigned IF_SIGNED = 0,
    parameter int unsigned SAT_EN    = 1
) (
    input  logic                       gclk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [LANES*IF_W-1:0]      ifmap,
    input  logic                       flt_load,
    input  logic [LANES*FLT_W-1:0]     filter,
    input  logic                       acc_mode,
    input  logic                       acc_clr,
    input  logic signed [PSUM_W-1:0]   psum_in,
    output logic signed [PSUM_W-1:0]   psum_out,
    output logic                       out_valid,
    output logic                       ovf
);

    localparam int unsigned P_W = IF_W + FLT_W + 1;
    localparam int unsigned S_W = P_W + $clog2(LANES);
    localparam int unsigned F_W = ((S_W > PSUM_W) ? S_W : PSUM_W) + 1;

    localparam logic signed [F_W-1:0] P_MAX = {{(F_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic signed [F_W-1:0] P_MIN = {{(F_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    logic [LANES*IF_W-1:0]   ifmap_q;
    logic [LANES*FLT_W-1:0]  flt_q;
    logic                    v1;
    logic                    v2;
    logic signed [P_W-1:0]   prod_d [LANES];
    logic signed [P_W-1:0]   prod   [LANES];

    logic signed [S_W-1:0]    dot;
    logic signed [PSUM_W-1:0] base;
    logic signed [F_W-1:0]    sum_full;
    logic                     range_hi;
    logic                     range_lo;
    logic signed [PSUM_W-1:0] fit_val;
    logic signed [PSUM_W-1:0] psum_d;
    logic                     valid_d;
    logic                     ovf_d;

    // Per-lane operand extension and multiply; products are exact at P_W bits
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [P_W-1:0] a_ext;
        logic signed [P_W-1:0] f_ext;
        if (IF_SIGNED != 0) begin : g_s
            assign a_ext = P_W'($signed(ifmap_q[i*IF_W +: IF_W]));
        end else begin : g_u
            assign a_ext = P_W'(ifmap_q[i*IF_W +: IF_W]);
        end
        assign f_ext     = P_W'($signed(flt_q[i*FLT_W +: FLT_W]));
        assign prod_d[i] = a_ext * f_ext;
    end

    // Stages 1 and 2: operand capture, filter register, product register, valid pipe
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            ifmap_q <= '0;
            flt_q   <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            if (in_valid) ifmap_q <= ifmap;
            if (flt_load) flt_q <= filter;
            v1 <= in_valid;
            v2 <= v1;
            for (int i = 0; i < LANES; i++) prod[i] <= prod_d[i];
        end
    end

    always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++) dot = dot + S_W'(prod[i]);
    end

    // Full-precision add, then range check and fit into PSUM_W
    always_comb begin
        base = '0;
        if (!acc_mode)     base = psum_in;
        else if (!acc_clr) base = psum_out;
        sum_full = F_W'(dot) + F_W'(base);
        range_hi = (sum_full > P_MAX);
        range_lo = (sum_full < P_MIN);
        fit_val  = sum_full[PSUM_W-1:0];
        if (SAT_EN != 0) begin
            if (range_hi) fit_val = P_MAX[PSUM_W-1:0];
            if (range_lo) fit_val = P_MIN[PSUM_W-1:0];
        end
    end

    always_comb begin
        psum_d  = psum_out;
        valid_d = 1'b0;
        ovf_d   = ovf;
        if (!acc_mode) begin
            if (v2) begin
                psum_d  = fit_val;
                valid_d = 1'b1;
                ovf_d   = ovf | range_hi | range_lo;
            end else begin
                psum_d  = psum_in;
            end
            if (acc_clr) ovf_d = 1'b0;
        end else if (acc_clr) begin
            psum_d  = v2 ? fit_val : '0;
            valid_d = v2;
            ovf_d   = v2 & (range_hi | range_lo);
        end else if (v2) begin
            psum_d  = fit_val;
            valid_d = 1'b1;
            ovf_d   = ovf | range_hi | range_lo;
        end
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            psum_out  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            psum_out  <= psum_d;
            out_valid <= valid_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pe_mac_simd.sv
// Bench for pe_mac_simd: default, 16-bit saturating and 16-bit wrapping instances
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_pe_mac_simd;

    localparam int unsigned LANES = 4;

    logic                gclk;
    logic                rst;
    logic                in_valid;
    logic [31:0]         ifmap;
    logic                flt_load;
    logic [31:0]         filter;
    logic                acc_mode;
    logic                acc_clr;
    logic signed [23:0]  psum_in;
    logic signed [15:0]  psum_in_n;

    logic signed [23:0]  po_def;
    logic signed [15:0]  po_sat;
    logic signed [15:0]  po_wrap;
    logic                ov_def, ov_sat, ov_wrap;
    logic                of_def, of_sat, of_wrap;

    int ncmp  = 0;
    int nfail = 0;

    // reference model state, index 0 = default, 1 = 16-bit sat, 2 = 16-bit wrap
    longint m_psum  [3];
    bit     m_valid [3];
    bit     m_ovf   [3];
    int     m_flt   [LANES];
    bit     m_pv    [2];
    longint m_pdot  [2];

    assign psum_in_n = psum_in[15:0];

    pe_mac_simd u_def (
        .gclk(gclk), .rst(rst), .in_valid(in_valid), .ifmap(ifmap),
        .flt_load(flt_load), .filter(filter), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .psum_in(psum_in), .psum_out(po_def), .out_valid(ov_def), .ovf(of_def)
    );

    pe_mac_simd #(.PSUM_W(16), .SAT_EN(1)) u_sat (
        .gclk(gclk), .rst(rst), .in_valid(in_valid), .ifmap(ifmap),
        .flt_load(flt_load), .filter(filter), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .psum_in(psum_in_n), .psum_out(po_sat), .out_valid(ov_sat), .ovf(of_sat)
    );

    pe_mac_simd #(.PSUM_W(16), .SAT_EN(0)) u_wrap (
        .gclk(gclk), .rst(rst), .in_valid(in_valid), .ifmap(ifmap),
        .flt_load(flt_load), .filter(filter), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .psum_in(psum_in_n), .psum_out(po_wrap), .out_valid(ov_wrap), .ovf(of_wrap)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic longint wrapw(input longint x, input int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic fitm(input longint x, input int w, input bit sat,
                        output longint r, output bit o);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        o  = (x > mx) || (x < mn);
        r  = x;
        if (o) r = sat ? ((x > mx) ? mx : mn) : wrapw(x, w);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_psum[c] = 0; m_valid[c] = 0; m_ovf[c] = 0;
        end
        for (int i = 0; i < LANES; i++) m_flt[i] = 0;
        m_pv[0] = 0; m_pv[1] = 0; m_pdot[0] = 0; m_pdot[1] = 0;
    endtask

    // Effect of one clock edge given the inputs that were applied before it
    task automatic model_edge(input bit iv, input bit [31:0] ifm, input bit fl,
                              input bit [31:0] flt, input bit am, input bit ac, input int pin);
        int     w;
        bit     sat;
        longint pc;
        longint r;
        bit     o;
        longint d;
        byte    fb;
        for (int c = 0; c < 3; c++) begin
            w   = (c == 0) ? 24 : 16;
            sat = (c != 2);
            pc  = wrapw(longint'(pin), w);
            if (!am) begin
                if (m_pv[1]) begin
                    fitm(m_pdot[1] + pc, w, sat, r, o);
                    m_psum[c] = r; m_valid[c] = 1; m_ovf[c] = m_ovf[c] | o;
                end else begin
                    m_psum[c] = pc; m_valid[c] = 0;
                end
                if (ac) m_ovf[c] = 0;
            end else if (ac) begin
                if (m_pv[1]) begin
                    fitm(m_pdot[1], w, sat, r, o);
                    m_psum[c] = r; m_valid[c] = 1; m_ovf[c] = o;
                end else begin
                    m_psum[c] = 0; m_valid[c] = 0; m_ovf[c] = 0;
                end
            end else if (m_pv[1]) begin
                fitm(m_psum[c] + m_pdot[1], w, sat, r, o);
                m_psum[c] = r; m_valid[c] = 1; m_ovf[c] = m_ovf[c] | o;
            end else begin
                m_valid[c] = 0;
            end
        end
        if (fl) begin
            for (int i = 0; i < LANES; i++) begin
                fb = flt[i*8 +: 8];
                m_flt[i] = fb;
            end
        end
        m_pv[1]   = m_pv[0];
        m_pdot[1] = m_pdot[0];
        m_pv[0]   = iv;
        if (iv) begin
            d = 0;
            for (int i = 0; i < LANES; i++) d += longint'(ifm[i*8 +: 8]) * m_flt[i];
            m_pdot[0] = d;
        end
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/def_psum"},  po_def,  m_psum[0]);
        chk({tag, "/def_vld"},   ov_def,  m_valid[0]);
        chk({tag, "/def_ovf"},   of_def,  m_ovf[0]);
        chk({tag, "/sat_psum"},  po_sat,  m_psum[1]);
        chk({tag, "/sat_vld"},   ov_sat,  m_valid[1]);
        chk({tag, "/sat_ovf"},   of_sat,  m_ovf[1]);
        chk({tag, "/wrap_psum"}, po_wrap, m_psum[2]);
        chk({tag, "/wrap_vld"},  ov_wrap, m_valid[2]);
        chk({tag, "/wrap_ovf"},  of_wrap, m_ovf[2]);
    endtask

    task automatic step(input string tag, input bit iv, input bit [31:0] ifm, input bit fl,
                        input bit [31:0] flt, input bit am, input bit ac, input int pin);
        in_valid = iv; ifmap = ifm; flt_load = fl; filter = flt;
        acc_mode = am; acc_clr = ac; psum_in = 24'(pin);
        @(posedge gclk);
        model_edge(iv, ifm, fl, flt, am, ac, pin);
        #1;
        check_all(tag);
    endtask

    localparam logic [31:0] F_P2  = 32'hFC03_FE01;
    localparam logic [31:0] I_P2  = 32'h281E_140A;

    initial begin
        bit [23:0] rp;
        bit        am_r;
        rst = 1'b1; in_valid = 0; ifmap = '0; flt_load = 0; filter = '0;
        acc_mode = 0; acc_clr = 0; psum_in = '0;
        model_reset();
        #12;
        chk("rst/psum", po_def, 0);
        chk("rst/vld",  ov_def, 0);
        chk("rst/ovf",  of_def, 0);
        rst = 1'b0;

        // systolic dot product with two upstream sums
        step("p2a_n",  1, I_P2, 1, F_P2, 0, 0, 0);
        step("p2a_n1", 0, 0, 0, 0, 0, 0, 0);
        step("p2a_n2", 0, 0, 0, 0, 0, 0, 100);
        chk("p2a_zero", po_def, 0);
        chk("p2a_vld",  ov_def, 1);
        step("p2b_n",  1, I_P2, 0, 0, 0, 0, 0);
        step("p2b_n1", 0, 0, 0, 0, 0, 0, 0);
        step("p2b_n2", 0, 0, 0, 0, 0, 0, 5);
        chk("p2b_m95", po_def, -95);

        // extremes, back-to-back; same samples overflow the 16-bit instances
        step("p3_s0", 1, 32'hFFFF_FFFF, 1, 32'h8080_8080, 0, 0, 0);
        step("p3_s1", 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        step("p3_o0", 0, 0, 0, 0, 0, 0, 0);
        chk("p3_o0_val", po_def, -130560);
        chk("p3_o0_vld", ov_def, 1);
        step("p3_o1", 0, 0, 0, 0, 0, 0, 0);
        chk("p3_o1_val", po_def, -130560);
        chk("p3_o1_vld", ov_def, 1);
        chk("p3_ovf",    of_def, 0);

        step("p4_n",  1, 32'hFFFF_FFFF, 1, 32'h7F7F_7F7F, 0, 0, 0);
        step("p4_n1", 0, 0, 0, 0, 0, 0, 0);
        step("p4_n2", 0, 0, 0, 0, 0, 0, 0);
        chk("p4_sat_val",  po_sat, 32767);
        chk("p4_sat_ovf",  of_sat, 1);
        chk("p4_wrap_val", po_wrap, -1532);
        chk("p4_wrap_ovf", of_wrap, 1);
        chk("p4_def_val",  po_def, 129540);

        // local accumulation with clear-and-start on the first sample
        step("p5_a", 1, 32'h0202_0202, 1, 32'h0101_0101, 1, 0, 0);
        step("p5_b", 1, 32'h0202_0202, 0, 0, 1, 0, 0);
        step("p5_c", 1, 32'h0202_0202, 0, 0, 1, 1, 0);
        chk("p5_8",  po_def, 8);
        step("p5_d", 0, 0, 0, 0, 1, 0, 0);
        chk("p5_16", po_def, 16);
        step("p5_e", 0, 0, 0, 0, 1, 0, 0);
        chk("p5_24", po_def, 24);
        step("p5_clr", 0, 0, 0, 0, 1, 1, 0);
        chk("p5_clr_val", po_def, 0);
        chk("p5_clr_vld", ov_def, 0);
        chk("p5_clr_ovf", of_sat, 0);

        // bypass, then filter reload right after a sample
        step("p6_byp", 0, 0, 0, 0, 0, 0, 32'h00AB_CD);
        chk("p6_byp_val", po_def, 32'h00AB_CD);
        chk("p6_byp_vld", ov_def, 0);
        step("p6_s",  1, 32'h0202_0202, 1, 32'h0101_0101, 0, 0, 0);
        step("p6_f2", 0, 0, 1, 32'h0202_0202, 0, 0, 0);
        step("p6_o",  0, 0, 0, 0, 0, 0, 0);
        chk("p6_flt1", po_def, 8);

        // randomized traffic
        am_r = 0;
        for (int n = 0; n < 400; n++) begin
            rp = 24'($urandom);
            if ($urandom_range(0, 15) == 0) am_r = ~am_r;
            step("rnd", $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 $urandom, am_r, $urandom_range(0, 9) == 0, int'($signed(rp)));
        end

        // reset mid-stream with samples in flight
        step("r_s0", 1, $urandom, 1, $urandom, 0, 0, 0);
        step("r_s1", 1, $urandom, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rmid/psum", po_def, 0);
        chk("rmid/vld",  ov_def, 0);
        chk("rmid/ovf",  of_def, 0);
        check_all("rmid");
        #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step("rpost", 0, 0, 0, 0, 0, 0, 0);
            chk("rpost/vld", ov_def, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pe_mac_simd.md
Name: pe_mac_simd

Overview:
Parametrised successor of the single-lane systolic PE, used in the CNN accelerator array.
- Each cycle it computes a LANES-wide dot product of ifmap and filter values through a 3-stage pipeline with valid tracking.
- The filter is weight-stationary, held in a register loaded on command.
- Two output modes: systolic pass-down, where the dot product is added to psum_in, or local accumulation (output-stationary), with optional saturation.

Parameters:
IF_W, 8, ifmap element width
FLT_W, 8, filter element width (always signed)
LANES, 4, multiply lanes per PE (>=1)
PSUM_W, 24, partial-sum width
IF_SIGNED, 0, 1 = ifmap signed; 0 = ifmap unsigned (zero-extended)
SAT_EN, 1, 1 = saturate psum result; 0 = two's-complement wrap

Ports:
gclk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ifmap sample valid this cycle
ifmap  in  LANES*IF_W  lane i at bits [i*IF_W +: IF_W]
flt_load  in  1  load filter register
filter  in  LANES*FLT_W  lane i at bits [i*FLT_W +: FLT_W]
acc_mode  in  1  0 = systolic (add psum_in), 1 = local accumulate
acc_clr  in  1  synchronous clear of accumulator and ovf
psum_in  in  PSUM_W  upstream partial sum, signed
psum_out  out  PSUM_W  registered partial sum / accumulator, signed
out_valid  out  1  psum_out holds a new dot-product result
ovf  out  1  sticky overflow flag

Behaviour:
Reset:
- rst asynchronously clears all registers.
- psum_out = 0, out_valid = 0, ovf = 0; filter reg, ifmap reg and products = 0; valid pipe v1, v2 = 0.

Stage 1 (edge N, where N is the in_valid cycle):
- if in_valid: ifmap_q <= ifmap. v1 <= in_valid.
- if flt_load: flt_q <= filter (independent of in_valid).

Stage 2 (edge N+1):
- prod[i] <= ext(ifmap_q[i]) * flt_q[i].
- Product width P_W = IF_W + FLT_W + 1; ifmap is sign- or zero-extended per IF_SIGNED.
- v2 <= v1.
- A sample uses the filter loaded at or before its in_valid cycle. A flt_load one cycle later does not affect it.

Stage 3 (edge N+2, output register):
- dot = signed sum of prod[0..LANES-1] at width S_W = P_W + clog2(LANES), combinational adder tree.
- Full-precision add at width max(S_W, PSUM_W) + 1, then range-check against PSUM_W.
- acc_mode = 0:
  - if v2: psum_out <= fit(dot + psum_in), out_valid <= 1.
  - else: psum_out <= psum_in (registered bypass), out_valid <= 0.
  - psum_in is sampled in cycle N+2, aligned with the sample's v2.
- acc_mode = 1 (psum_in ignored):
  - acc_clr & v2: psum_out <= fit(dot), out_valid <= 1 (clear-and-start).
  - acc_clr & !v2: psum_out <= 0, out_valid <= 0.
  - !acc_clr & v2: psum_out <= fit(psum_out + dot), out_valid <= 1.
  - else: psum_out holds, out_valid <= 0.
- acc_mode is sampled per cycle at stage 3. Switching mode mid-stream applies to whichever sample is in stage 3 that cycle.

Latency: in_valid at cycle N -> out_valid/psum_out valid after edge N+2, i.e. visible in cycle N+3. Throughput: 1 sample per cycle.

fit() and ovf:
- Out of PSUM_W range with SAT_EN = 1: clamp to +2^(PSUM_W-1)-1 or -2^(PSUM_W-1).
- Out of range with SAT_EN = 0: keep low PSUM_W bits.
- Either case sets ovf (sticky).
- ovf clears only on rst or acc_clr. acc_clr takes priority over a simultaneous overflow, except when acc_clr & v2 itself overflows, in which case ovf = 1.
- Bypass never sets ovf.

Reset mid-operation: in-flight samples are discarded; no out_valid is produced for them after rst deasserts.

Test Plan:
1. Reset: assert rst mid-stream with v1/v2 set -> psum_out = 0, out_valid = 0, ovf = 0 immediately; no out_valid in the following 3 cycles with in_valid = 0.
2. Systolic dot (defaults):
   - Stimulus: flt_load filter {1,-2,3,-4}; ifmap {10,20,30,40} at cycle N; psum_in = 100 at N+2.
   - Required: psum_out = 0, out_valid = 1 in cycle N+3.
   - Same stimulus with psum_in = 5 -> psum_out = -95.
3. Extremes (defaults): ifmap all 255, filter all -128, psum_in 0 -> psum_out = -130560, ovf = 0. Back-to-back samples on consecutive cycles produce consecutive out_valid.
4. Saturation/wrap (PSUM_W = 16):
   - Stimulus: ifmap all 255, filter all 127, systolic, psum_in 0.
   - SAT_EN = 1 -> psum_out = 32767, ovf = 1.
   - SAT_EN = 0 -> psum_out = -1532, ovf = 1.
5. Accumulate (defaults): acc_mode = 1, filter all 1, ifmap all 2 for 3 samples with acc_clr on the first -> psum_out 8, 16, 24. acc_clr alone -> psum_out = 0, out_valid = 0, ovf cleared.
6. Bypass and filter timing:
   - in_valid = 0, psum_in = 0x00ABCD -> psum_out = 0x00ABCD next cycle, out_valid = 0.
   - flt_load of filter 2 one cycle after a sample loaded with filter 1 -> that sample still uses filter 1.
